// File: rtl/axi_rd_arbiter_2to1_pkg.sv
// Shared AXI field widths and FSM encoding for the two-master AXI read arbiter.
// Also holds the two-request round-robin pick helper used by the arbiter core.
package axi_rd_arbiter_2to1_pkg;

  localparam int DEFAULT_BW_AXI_TID = 4;
  localparam int BW_AXI_ALEN        = 8;
  localparam int BW_AXI_ASIZE       = 3;
  localparam int BW_AXI_ABURST      = 2;
  localparam int BW_AXI_RRESP       = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // The pointer master wins when it requests, otherwise the other one does.
  function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
    return req[ptr] ? ptr : ~ptr;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_2to1_rr.sv
// Two-request round-robin picker.
// Owns the priority pointer, which moves past the master that last finished a burst.
module axi_rr_arbiter2
  import axi_rd_arbiter_2to1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_last_grant,
  output logic       o_winner,
  output logic       o_any
);

  logic r_ptr;

  assign o_winner = rr_pick(i_req, r_ptr);
  assign o_any    = |i_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_update) begin
      r_ptr <= ~i_last_grant;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter_2to1.sv
// Two-master, one-slave AXI read arbiter: one outstanding burst at a time,
// round-robin grant, R beats steered back to the owner until RLAST.
module axi_rd_arbiter_2to1
  import axi_rd_arbiter_2to1_pkg::*;
#(
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 32,
  parameter int BW_AXI_TID = DEFAULT_BW_AXI_TID
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BW_AXI_TID-1:0]    m0_arid,
  input  logic [BW_ADDR-1:0]       m0_araddr,
  input  logic [BW_AXI_ALEN-1:0]   m0_arlen,
  input  logic [BW_AXI_ASIZE-1:0]  m0_arsize,
  input  logic [BW_AXI_ABURST-1:0] m0_arburst,
  input  logic                     m0_arvalid,
  output logic                     m0_arready,
  output logic [BW_AXI_TID-1:0]    m0_rid,
  output logic [BW_DATA-1:0]       m0_rdata,
  output logic [BW_AXI_RRESP-1:0]  m0_rresp,
  output logic                     m0_rlast,
  output logic                     m0_rvalid,
  input  logic                     m0_rready,
  input  logic [BW_AXI_TID-1:0]    m1_arid,
  input  logic [BW_ADDR-1:0]       m1_araddr,
  input  logic [BW_AXI_ALEN-1:0]   m1_arlen,
  input  logic [BW_AXI_ASIZE-1:0]  m1_arsize,
  input  logic [BW_AXI_ABURST-1:0] m1_arburst,
  input  logic                     m1_arvalid,
  output logic                     m1_arready,
  output logic [BW_AXI_TID-1:0]    m1_rid,
  output logic [BW_DATA-1:0]       m1_rdata,
  output logic [BW_AXI_RRESP-1:0]  m1_rresp,
  output logic                     m1_rlast,
  output logic                     m1_rvalid,
  input  logic                     m1_rready,
  output logic [BW_AXI_TID-1:0]    s_arid,
  output logic [BW_ADDR-1:0]       s_araddr,
  output logic [BW_AXI_ALEN-1:0]   s_arlen,
  output logic [BW_AXI_ASIZE-1:0]  s_arsize,
  output logic [BW_AXI_ABURST-1:0] s_arburst,
  output logic                     s_arvalid,
  input  logic                     s_arready,
  input  logic [BW_AXI_TID-1:0]    s_rid,
  input  logic [BW_DATA-1:0]       s_rdata,
  input  logic [BW_AXI_RRESP-1:0]  s_rresp,
  input  logic                     s_rlast,
  input  logic                     s_rvalid,
  output logic                     s_rready,
  output logic                     grant_idx,
  output logic                     busy,
  output logic                     beat_error
);

  arb_state_e             r_state;
  logic                   r_grant;
  logic                   r_busy;
  logic                   r_beat_error;
  logic [BW_AXI_ALEN-1:0] r_beat_cnt;
  logic [BW_AXI_ALEN-1:0] r_len_q;

  logic w_winner;
  logic w_any;
  logic w_in_addr;
  logic w_in_data;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_rr_update;

  assign w_in_addr   = (r_state == ST_ADDR);
  assign w_in_data   = (r_state == ST_DATA);
  assign w_ar_hs     = s_arvalid & s_arready;
  assign w_r_hs      = s_rvalid & s_rready;
  assign w_rr_update = w_in_data & w_r_hs & s_rlast;

  axi_rr_arbiter2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .i_req       ({m1_arvalid, m0_arvalid}),
    .i_update    (w_rr_update),
    .i_last_grant(r_grant),
    .o_winner    (w_winner),
    .o_any       (w_any)
  );

  // AR path: granted master is wired straight through only while in ADDR.
  always_comb begin
    s_arid     = '0;
    s_araddr   = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_arvalid  = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    if (w_in_addr) begin
      if (r_grant) begin
        s_arid     = m1_arid;
        s_araddr   = m1_araddr;
        s_arlen    = m1_arlen;
        s_arsize   = m1_arsize;
        s_arburst  = m1_arburst;
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
      end else begin
        s_arid     = m0_arid;
        s_araddr   = m0_araddr;
        s_arlen    = m0_arlen;
        s_arsize   = m0_arsize;
        s_arburst  = m0_arburst;
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
      end
    end
  end

  // R path: slave beats reach only the owner, and only in DATA.
  always_comb begin
    m0_rid    = '0;
    m0_rdata  = '0;
    m0_rresp  = '0;
    m0_rlast  = 1'b0;
    m0_rvalid = 1'b0;
    m1_rid    = '0;
    m1_rdata  = '0;
    m1_rresp  = '0;
    m1_rlast  = 1'b0;
    m1_rvalid = 1'b0;
    s_rready  = 1'b0;
    if (w_in_data) begin
      if (r_grant) begin
        m1_rid    = s_rid;
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
        m1_rlast  = s_rlast;
        m1_rvalid = s_rvalid;
        s_rready  = m1_rready;
      end else begin
        m0_rid    = s_rid;
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
        m0_rlast  = s_rlast;
        m0_rvalid = s_rvalid;
        s_rready  = m0_rready;
      end
    end
  end

  // An rlast that is early, or a beat at the last index without rlast, flags the burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_busy       <= 1'b0;
      r_beat_error <= 1'b0;
      r_beat_cnt   <= '0;
      r_len_q      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_winner;
            r_busy  <= 1'b1;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_ar_hs) begin
            r_len_q    <= s_arlen;
            r_beat_cnt <= '0;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_r_hs) begin
            r_beat_cnt <= r_beat_cnt + BW_AXI_ALEN'(1);
            if (s_rlast != (r_beat_cnt == r_len_q)) begin
              r_beat_error <= 1'b1;
            end
            if (s_rlast) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant_idx  = r_grant;
  assign busy       = r_busy;
  assign beat_error = r_beat_error;

endmodule

// File: tb/tb_axi_rd_arbiter_2to1.sv
// Self-checking bench for axi_rd_arbiter_2to1: the bench plays both masters and the slave,
// using a table of grant scenarios, hand-written corner sequences and a randomized run.
module tb_axi_rd_arbiter_2to1;
  import axi_rd_arbiter_2to1_pkg::*;

  localparam int TW = DEFAULT_BW_AXI_TID;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0][TW-1:0]          mArid;
  logic [1:0][31:0]            mAraddr;
  logic [1:0][BW_AXI_ALEN-1:0] mArlen;
  logic [1:0][2:0]             mArsize;
  logic [1:0][1:0]             mArburst;
  logic [1:0]                  mArvalid;
  logic [1:0]                  mRready;
  wire  [1:0]                  mArready;
  wire  [1:0]                  mRvalid;
  wire  [1:0]                  mRlast;
  wire  [1:0][TW-1:0]          mRid;
  wire  [1:0][31:0]            mRdata;
  wire  [1:0][1:0]             mRresp;

  wire  [TW-1:0]          s_arid;
  wire  [31:0]            s_araddr;
  wire  [BW_AXI_ALEN-1:0] s_arlen;
  wire  [2:0]             s_arsize;
  wire  [1:0]             s_arburst;
  wire                    s_arvalid;
  wire                    s_rready;
  logic                   sArready;
  logic [TW-1:0]          sRid;
  logic [31:0]            sRdata;
  logic [1:0]             sRresp;
  logic                   sRlast;
  logic                   sRvalid;
  wire                    grant_idx;
  wire                    busy;
  wire                    beat_error;

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    bit         req0;
    bit         req1;
    logic [7:0] len;
    int         expGrant;
  } vec_t;

  vec_t vecs[6];

  axi_rd_arbiter_2to1 dut (
    .clk(clk), .rst(rst),
    .m0_arid(mArid[0]), .m0_araddr(mAraddr[0]), .m0_arlen(mArlen[0]),
    .m0_arsize(mArsize[0]), .m0_arburst(mArburst[0]),
    .m0_arvalid(mArvalid[0]), .m0_arready(mArready[0]),
    .m0_rid(mRid[0]), .m0_rdata(mRdata[0]), .m0_rresp(mRresp[0]), .m0_rlast(mRlast[0]),
    .m0_rvalid(mRvalid[0]), .m0_rready(mRready[0]),
    .m1_arid(mArid[1]), .m1_araddr(mAraddr[1]), .m1_arlen(mArlen[1]),
    .m1_arsize(mArsize[1]), .m1_arburst(mArburst[1]),
    .m1_arvalid(mArvalid[1]), .m1_arready(mArready[1]),
    .m1_rid(mRid[1]), .m1_rdata(mRdata[1]), .m1_rresp(mRresp[1]), .m1_rlast(mRlast[1]),
    .m1_rvalid(mRvalid[1]), .m1_rready(mRready[1]),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(sArready),
    .s_rid(sRid), .s_rdata(sRdata), .s_rresp(sRresp), .s_rlast(sRlast),
    .s_rvalid(sRvalid), .s_rready(s_rready),
    .grant_idx(grant_idx), .busy(busy), .beat_error(beat_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    mArid = '0; mAraddr = '0; mArlen = '0; mArsize = '0; mArburst = '0;
    mArvalid = 2'b00; mRready = 2'b00;
    sArready = 1'b0; sRid = '0; sRdata = '0; sRresp = '0; sRlast = 1'b0; sRvalid = 1'b0;
  endtask

  task automatic resetDut();
    idleInputs();
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input bit r0, input bit r1, input logic [7:0] l0, input logic [7:0] l1);
    for (int i = 0; i < 2; i++) begin
      mArid[i]    = TW'($urandom);
      mAraddr[i]  = $urandom;
      mArsize[i]  = 3'($urandom);
      mArburst[i] = 2'($urandom);
    end
    mArlen[0] = l0;
    mArlen[1] = l1;
    mArvalid  = {r1, r0};
  endtask

  // Called in the IDLE cycle the request is raised; returns after the AR handshake edge.
  task automatic arPhase(input int expWho);
    int other;
    bit done;
    other   = 1 - expWho;
    done    = 1'b0;
    sRvalid = 1'b1;
    mRready = 2'b11;
    @(negedge clk);
    checkOutput("ar_latency", s_arvalid, 0);
    checkOutput("rready_idle", s_rready, 0);
    for (int c = 0; c < 12 && !done; c++) begin
      nextCycle();
      sArready = (c >= 3) ? 1'b1 : 1'($urandom);
      @(negedge clk);
      checkOutput("s_arvalid", s_arvalid, 1);
      checkOutput("grant_idx", grant_idx, expWho);
      checkOutput("busy_addr", busy, 1);
      checkOutput("s_araddr", s_araddr, mAraddr[expWho]);
      checkOutput("s_arid", s_arid, mArid[expWho]);
      checkOutput("s_arlen", s_arlen, mArlen[expWho]);
      checkOutput("s_arsize", s_arsize, mArsize[expWho]);
      checkOutput("s_arburst", s_arburst, mArburst[expWho]);
      checkOutput("arready_fwd", mArready[expWho], sArready);
      checkOutput("arready_other", mArready[other], 0);
      checkOutput("rready_addr", s_rready, 0);
      checkOutput("rvalid_addr", mRvalid, 0);
      if (sArready) done = 1'b1;
    end
    checkOutput("ar_handshake", done, 1);
    nextCycle();
    mArvalid = 2'b00;
    sArready = 1'b0;
    sRvalid  = 1'b0;
    mRready  = 2'b00;
  endtask

  // Slave sends beats 0..lastAt with rlast on beat lastAt; ends one cycle into IDLE.
  task automatic rBurst(input int who, input int lastAt, input bit toggle, input bit gaps);
    int other;
    int b;
    int cyc;
    logic [31:0] data;
    other = 1 - who;
    b     = 0;
    cyc   = 0;
    while (b <= lastAt && cyc < 200) begin
      data    = $urandom;
      sRdata  = data;
      sRid    = TW'($urandom);
      sRresp  = 2'($urandom);
      sRvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      sRlast  = (b == lastAt);
      mRready[who]   = toggle ? (cyc % 2 == 0) : 1'b1;
      mRready[other] = 1'($urandom);
      @(negedge clk);
      checkOutput("rvalid_fwd", mRvalid[who], sRvalid);
      checkOutput("rvalid_other", mRvalid[other], 0);
      checkOutput("rready_fwd", s_rready, mRready[who]);
      if (sRvalid) begin
        checkOutput("rdata", mRdata[who], data);
        checkOutput("rid", mRid[who], sRid);
        checkOutput("rresp", mRresp[who], sRresp);
        checkOutput("rlast", mRlast[who], sRlast);
      end
      if (sRvalid && mRready[who]) b++;
      cyc++;
      nextCycle();
    end
    checkOutput("r_beats", b, lastAt + 1);
    sRlast  = 1'b0;
    sRvalid = 1'b1;
    mRready = 2'b11;
    @(negedge clk);
    checkOutput("busy_after", busy, 0);
    checkOutput("rready_after", s_rready, 0);
    checkOutput("rvalid_after", mRvalid, 0);
    nextCycle();
    sRvalid = 1'b0;
    mRready = 2'b00;
  endtask

  initial begin
    int arCnt;
    int lastCyc;
    int ptr;
    bit err;
    int win;
    int lastAt;
    logic [1:0] req;
    logic [7:0] l0;
    logic [7:0] l1;

    vecs[0] = '{1'b1, 1'b0, 8'd2, 0};
    vecs[1] = '{1'b1, 1'b1, 8'd0, 1};
    vecs[2] = '{1'b1, 1'b1, 8'd3, 0};
    vecs[3] = '{1'b1, 1'b0, 8'd1, 0};
    vecs[4] = '{1'b0, 1'b1, 8'd4, 1};
    vecs[5] = '{1'b1, 1'b1, 8'd0, 0};

    // Reset held with both masters requesting and slave beats offered.
    idleInputs();
    rst      = 1'b1;
    mArvalid = 2'b11;
    sRvalid  = 1'b1;
    mRready  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_arready", mArready, 0);
      checkOutput("rst_s_arvalid", s_arvalid, 0);
      checkOutput("rst_s_araddr", s_araddr, 0);
      checkOutput("rst_s_rready", s_rready, 0);
      checkOutput("rst_rvalid", mRvalid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_grant", grant_idx, 0);
      checkOutput("rst_beat_error", beat_error, 0);
    end
    idleInputs();
    nextCycle();
    rst = 1'b0;

    // Grant order from a fresh pointer across single and contended requests.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].req0, vecs[i].req1, vecs[i].len, vecs[i].len);
      arPhase(vecs[i].expGrant);
      rBurst(vecs[i].expGrant, int'(vecs[i].len), 1'b0, 1'b1);
      checkOutput("tbl_beat_error", beat_error, 0);
    end

    // Continuous contention with single-beat bursts: alternation and AR spacing.
    resetDut();
    applyStimulus(1'b1, 1'b1, 8'd0, 8'd0);
    sArready = 1'b1;
    sRvalid  = 1'b1;
    sRlast   = 1'b1;
    mRready  = 2'b11;
    arCnt    = 0;
    lastCyc  = -100;
    for (int c = 0; c < 40 && arCnt < 4; c++) begin
      @(negedge clk);
      if (!busy || s_arvalid) checkOutput("ct_rready_blocked", s_rready, 0);
      if (s_arvalid && sArready) begin
        checkOutput("ct_grant", grant_idx, arCnt % 2);
        if (arCnt > 0) checkOutput("ct_spacing", c - lastCyc, 2);
        arCnt++;
      end
      if (sRvalid && s_rready && sRlast) lastCyc = c;
      nextCycle();
    end
    checkOutput("ct_count", arCnt, 4);
    mArvalid = 2'b00;
    nextCycle();
    idleInputs();
    nextCycle();
    checkOutput("ct_idle", busy, 0);

    // Backpressure: eight beats with the owner's rready toggling every cycle.
    applyStimulus(1'b1, 1'b0, 8'd7, 8'd0);
    arPhase(0);
    rBurst(0, 7, 1'b1, 1'b0);
    checkOutput("bp_beat_error", beat_error, 0);

    // Early rlast sets the sticky error; a later clean burst leaves it set.
    applyStimulus(1'b1, 1'b0, 8'd3, 8'd0);
    arPhase(0);
    rBurst(0, 1, 1'b0, 1'b0);
    checkOutput("len_err_set", beat_error, 1);
    applyStimulus(1'b0, 1'b1, 8'd2, 8'd2);
    arPhase(1);
    rBurst(1, 2, 1'b0, 1'b1);
    checkOutput("len_err_sticky", beat_error, 1);

    // Reset at beat 2 of 4, then a contended request is served from m0.
    applyStimulus(1'b1, 1'b0, 8'd3, 8'd0);
    arPhase(0);
    sRvalid = 1'b1;
    sRlast  = 1'b0;
    mRready = 2'b01;
    nextCycle();
    nextCycle();
    rst = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_rready", s_rready, 0);
    checkOutput("mid_rst_rvalid", mRvalid, 0);
    checkOutput("mid_rst_beat_error", beat_error, 0);
    rst = 1'b0;
    idleInputs();
    nextCycle();
    applyStimulus(1'b1, 1'b1, 8'd1, 8'd1);
    arPhase(0);
    rBurst(0, 1, 1'b0, 1'b0);
    checkOutput("post_rst_beat_error", beat_error, 0);

    // Randomized bursts against a grant/error model built from the arbitration rules.
    resetDut();
    ptr = 0;
    err = 1'b0;
    for (int t = 0; t < 40; t++) begin
      req = 2'($urandom_range(1, 3));
      l0  = 8'($urandom_range(0, 7));
      l1  = 8'($urandom_range(0, 7));
      win = req[ptr] ? ptr : 1 - ptr;
      lastAt = (win == 0) ? int'(l0) : int'(l1);
      if ($urandom_range(0, 4) == 0) lastAt = $urandom_range(0, 9);
      if (lastAt != ((win == 0) ? int'(l0) : int'(l1))) err = 1'b1;
      applyStimulus(req[0], req[1], l0, l1);
      arPhase(win);
      rBurst(win, lastAt, 1'($urandom), 1'b1);
      checkOutput("rnd_beat_error", beat_error, err);
      ptr = 1 - win;
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter_2to1.md
# axi_rd_arbiter_2to1

Two-master, one-slave AXI read-channel arbiter with round-robin grant, one outstanding burst at a time, and beat-count checking. It sits upstream of a shared AXI slave port, e.g. one output of an AXI split/broadcast stage or a memory controller, where two requesters share one read path. It serialises AR requests and steers the returning R beats back to the owning master until RLAST.

## Interface
- BW_ADDR, 32, address width
- BW_DATA, 32, data width
- BW_AXI_TID, `DEFAULT_BW_AXI_TID, ID width
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mN_arid/araddr/arlen/arsize/arburst (N=0,1)  input  BW_AXI_TID/BW_ADDR/`BW_AXI_ALEN/`BW_AXI_ASIZE/`BW_AXI_ABURST  master N read address
- mN_arvalid  input  1;  mN_arready  output  1
- mN_rid/rdata/rresp/rlast  output  BW_AXI_TID/BW_DATA/`BW_AXI_RRESP/1  read data to master N
- mN_rvalid  output  1;  mN_rready  input  1
- s_arid/araddr/arlen/arsize/arburst  output  same widths  address to shared slave
- s_arvalid  output  1;  s_arready  input  1
- s_rid/rdata/rresp/rlast  input  same widths;  s_rvalid  input  1;  s_rready  output  1
- grant_idx  output  1  index of master currently owning the slave (valid when busy=1)
- busy  output  1  FSM not in IDLE
- beat_error  output  1  sticky: RLAST position disagreed with granted ARLEN; cleared only by rst

## Operation
- FSM states IDLE, ADDR, DATA; registers: state, grant_idx, rr_ptr (1 bit), beat_cnt (`BW_AXI_ALEN bits), len_q.
- IDLE: all ready/valid outputs 0. If any mN_arvalid: winner = rr_ptr if that master requests, else the other; latch grant_idx=winner; go ADDR.
- ADDR: s_ar* = granted master's ar*, s_arvalid = granted mN_arvalid, granted mN_arready = s_arready; other master's arready=0. On s_arvalid&s_arready: latch len_q=arlen, beat_cnt=0, go DATA.
- DATA: granted mN_r* = s_r*, mN_rvalid = s_rvalid, s_rready = granted mN_rready; other master rvalid=0. Each R handshake: beat_cnt+1. On handshake with s_rlast=1: if beat_cnt!=len_q set beat_error; rr_ptr = ~grant_idx; go IDLE. Handshake with s_rlast=0 and beat_cnt==len_q also sets beat_error (burst continues until rlast).
- s_rvalid while in IDLE/ADDR is not forwarded; s_rready=0.
- Granted master deasserting arvalid in ADDR: grant held, state stays ADDR (AXI violation, no recovery).
- beat_cnt wraps at 2^`BW_AXI_ALEN; only compared, never saturates.

## Timing
- Reset values: state=IDLE, rr_ptr=0, grant_idx=0, busy=0, beat_error=0, every valid/ready output 0, payload outputs 0.
- Arbitration is registered: request seen in IDLE at cycle T, s_arvalid asserted at T+1. Minimum AR-to-AR spacing: last R beat at T, next grant at T+1, s_arvalid at T+2.
- ADDR and DATA forwarding is combinational (zero added latency); ready paths are combinational pass-through of the granted side.
- Simultaneous requests in IDLE: rr_ptr master wins; the loser is granted next if still requesting.
- rst asserted mid-burst: next cycle outputs return to reset values; in-flight slave beats dropped (rready=0).

## Structure
- Shared package/header: FSM state encoding localparams; AXI width macros from ervp_axi_define.vh.
- One sub-module natural: axi_rr_arbiter2 (2-request round-robin pick with pointer update); rest inline.

## Test plan
- Reset: hold rst 3 cycles with both arvalid=1 -> all ready/valid outputs 0, busy=0, grant_idx=0.
- Single master: m1 requests arlen=3 at T -> s_arvalid at T+1 with m1 fields; 4 R beats reach m1 only; m0_rvalid stays 0; busy drops after rlast.
- Contention: both request continuously, arlen=0 -> grants alternate 0,1,0,1; each AR issued 2 cycles after the prior rlast.
- Backpressure: m0 granted, arlen=7, m0_rready toggled 1/0 -> s_rready mirrors it, all 8 beats delivered in order, beat_error=0.
- Length mismatch: arlen=3, slave sends rlast on 2nd beat -> beat_error=1, FSM to IDLE, stays 1 across later clean bursts.
- Mid-burst reset: rst at beat 2 of 4 -> next cycle busy=0, s_rready=0; fresh request after reset served normally from m0.
